// File: rtl/input_capture_unit_if.sv
// Control/status bus between the timer control logic and the input-capture unit.
// The control logic owns the master side; the capture unit the slave side.
interface input_capture_unit_if #(
   parameter int DATA_W = 16
);
   logic              i_cap_en;
   logic              i_cap_clr;
   logic [1:0]        i_cap_edge;
   logic              i_cap_nc_en;
   logic              i_cap_rd;
   logic [DATA_W-1:0] i_cnt_data;
   logic              o_cap_ic_flg;
   logic [DATA_W-1:0] o_cap_cnt_data;
   logic              o_cap_not_empty;
   logic              o_cap_ovr;

   modport master (
      output i_cap_en, i_cap_clr, i_cap_edge, i_cap_nc_en, i_cap_rd, i_cnt_data,
      input  o_cap_ic_flg, o_cap_cnt_data, o_cap_not_empty, o_cap_ovr
   );

   modport slave (
      input  i_cap_en, i_cap_clr, i_cap_edge, i_cap_nc_en, i_cap_rd, i_cnt_data,
      output o_cap_ic_flg, o_cap_cnt_data, o_cap_not_empty, o_cap_ovr
   );
endinterface

// File: rtl/input_capture_unit.sv
// Input capture: pin synchroniser, optional noise canceller, edge detect and a
// small FIFO of counter snapshots with sticky overrun.
module input_capture_unit #(
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int NC_LEN      = 4
) (
   input  logic                 i_sysclk,
   input  logic                 i_sysrst_n,
   input  logic                 i_cap_pin,
   input_capture_unit_if.slave  cap
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(NC_LEN);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES:0]   vld_pipe;
   logic                   sync_out, blanking;
   logic                   filt_q, prev_q, nc_en_q;
   logic [CW-1:0]          nc_cnt;
   logic                   rise, fall, edge_hit, cap_evt;

   assign sync_out = sync_q[SYNC_STAGES-1];
   // vld_pipe fills with ones after release; edges are ignored until it is full
   assign blanking = ~vld_pipe[SYNC_STAGES];

   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         sync_q   <= '0;
         vld_pipe <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], i_cap_pin};
         vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      end
   end

   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         filt_q  <= 1'b0;
         prev_q  <= 1'b0;
         nc_cnt  <= '0;
         nc_en_q <= 1'b0;
      end else begin
         nc_en_q <= cap.i_cap_nc_en;
         if (blanking) begin
            filt_q <= sync_out;
            prev_q <= sync_out;
            nc_cnt <= '0;
         end else begin
            prev_q <= filt_q;
            if (!cap.i_cap_nc_en) begin
               filt_q <= sync_out;
               nc_cnt <= '0;
            end else if ((cap.i_cap_nc_en != nc_en_q) || (sync_out == filt_q)) begin
               nc_cnt <= '0;
            end else if (nc_cnt == CW'(NC_LEN-1)) begin
               filt_q <= sync_out;
               nc_cnt <= '0;
            end else begin
               nc_cnt <= nc_cnt + CW'(1);
            end
         end
      end
   end

   assign rise = filt_q & ~prev_q;
   assign fall = ~filt_q & prev_q;

   always_comb begin
      edge_hit = rise;
      case (cap.i_cap_edge)
         2'b01:   edge_hit = fall;
         2'b10:   edge_hit = rise | fall;
         default: edge_hit = rise;
      endcase
   end

   assign cap_evt = cap.i_cap_en & edge_hit & ~blanking;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              empty, full, pop, wr_en, ovr_q, flg_q;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = cap.i_cap_rd & ~empty;
   // full + pop: the write lands in the slot being vacated, so newest becomes tail
   assign wr_en = cap_evt & ~cap.i_cap_clr & (~full | pop);

   always_ff @(posedge i_sysclk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= cap.i_cnt_data;
   end

   always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
      if (!i_sysrst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovr_q  <= 1'b0;
         flg_q  <= 1'b0;
      end else begin
         flg_q <= cap_evt;
         if (cap.i_cap_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovr_q  <= 1'b0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
            if (cap_evt && full && !pop) ovr_q <= 1'b1;
         end
      end
   end

   assign cap.o_cap_ic_flg    = flg_q;
   assign cap.o_cap_not_empty = ~empty;
   assign cap.o_cap_cnt_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign cap.o_cap_ovr       = ovr_q;
endmodule

// File: tb/tb_input_capture_unit.sv
// Bench for input_capture_unit: directed scenarios plus randomized pin/control
// traffic, all checked every cycle against a queue-based reference model.
module tb_input_capture_unit;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int SS    = 2;
   localparam int NCL   = 4;

   logic clk, rst_n, pin;
   int   n_tests, n_fail;

   input_capture_unit_if #(.DATA_W(DW)) cap ();

   input_capture_unit #(
      .DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS), .NC_LEN(NCL)
   ) dut (
      .i_sysclk   (clk),
      .i_sysrst_n (rst_n),
      .i_cap_pin  (pin),
      .cap        (cap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pin history, filtered level as "stable for NCL samples",
   // and the FIFO as a bounded queue.
   logic [15:0]   ph;
   bit            nf_cur, nf_old, m_ovr, m_flg;
   int            rel;
   logic [DW-1:0] q[$];

   function automatic bit match(input logic [1:0] e, input bit r, input bit f);
      case (e)
         2'b01:   return f;
         2'b10:   return r | f;
         default: return r;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit r, f, evt, all_diff;
      if (!rst_n) begin
         ph = '0; nf_cur = 0; nf_old = 0; rel = 0; q.delete(); m_ovr = 0; m_flg = 0;
         return;
      end
      ph = {ph[14:0], pin};
      if (rel < 1000) rel++;
      r = nf_cur & ~nf_old;
      f = ~nf_cur & nf_old;
      evt = cap.i_cap_en && match(cap.i_cap_edge, r, f);
      m_flg = evt;
      // ph[SS] is the synchronised pin level presented to the filter at this edge
      if (rel <= SS + 1) begin
         nf_cur = ph[SS];
         nf_old = ph[SS];
      end else begin
         nf_old = nf_cur;
         if (!cap.i_cap_nc_en) nf_cur = ph[SS];
         else begin
            all_diff = 1;
            for (int k = SS; k < SS + NCL; k++) if (ph[k] == nf_cur) all_diff = 0;
            if (all_diff) nf_cur = ~nf_cur;
         end
      end
      if (cap.i_cap_clr) begin
         q.delete();
         m_ovr = 0;
      end else begin
         if (cap.i_cap_rd && q.size() > 0) void'(q.pop_front());
         if (evt) begin
            if (q.size() < DEPTH) q.push_back(cap.i_cnt_data);
            else m_ovr = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("flg",    32'(cap.o_cap_ic_flg),    32'(m_flg));
      chk("nempty", 32'(cap.o_cap_not_empty), 32'(q.size() != 0));
      chk("head",   32'(cap.o_cap_cnt_data),  32'((q.size() != 0) ? q[0] : '0));
      chk("ovr",    32'(cap.o_cap_ovr),       32'(m_ovr));
   endtask

   task automatic pulse(input logic [DW-1:0] c, input int hi, input int lo);
      cap.i_cnt_data = c;
      pin = 1'b1;
      repeat (hi) tick();
      pin = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic clear_fifo();
      cap.i_cap_clr = 1'b1;
      tick();
      cap.i_cap_clr = 1'b0;
   endtask

   task automatic rand_phase(input bit nc, input int cycles);
      int run;
      run = 0;
      cap.i_cap_nc_en = nc;
      repeat (10) tick();
      for (int i = 0; i < cycles; i++) begin
         if (run == 0) begin
            pin = ~pin;
            run = nc ? $urandom_range(1, 8) : $urandom_range(1, 5);
         end
         run--;
         cap.i_cnt_data = DW'($urandom);
         cap.i_cap_en   = ($urandom_range(0, 7) != 0);
         if (i % 20 == 0) cap.i_cap_edge = 2'($urandom_range(0, 3));
         cap.i_cap_rd   = ($urandom_range(0, 3) == 0);
         cap.i_cap_clr  = ($urandom_range(0, 39) == 0);
         tick();
      end
      cap.i_cap_rd  = 1'b0;
      cap.i_cap_clr = 1'b0;
      cap.i_cap_en  = 1'b1;
      repeat (12) tick();
   endtask

   initial begin
      int nflg;
      n_tests = 0; n_fail = 0;
      rst_n = 1'b1; pin = 1'b0;
      cap.i_cap_en = 1'b0; cap.i_cap_clr = 1'b0; cap.i_cap_edge = 2'b00;
      cap.i_cap_nc_en = 1'b0; cap.i_cap_rd = 1'b0; cap.i_cnt_data = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_flg",  32'(cap.o_cap_ic_flg),    32'(0));
      chk("rst_ne",   32'(cap.o_cap_not_empty), 32'(0));
      chk("rst_head", 32'(cap.o_cap_cnt_data),  32'(0));
      chk("rst_ovr",  32'(cap.o_cap_ovr),       32'(0));
      repeat (3) tick();
      rst_n = 1'b1;
      cap.i_cap_en = 1'b1;
      repeat (6) tick();

      // T1: bypass rising edge, flag on the 4th edge
      cap.i_cnt_data = 16'h1234;
      pin = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t1_flg", 32'(cap.o_cap_ic_flg), 32'(i == 4));
      end
      chk("t1_head", 32'(cap.o_cap_cnt_data),  32'h1234);
      chk("t1_ne",   32'(cap.o_cap_not_empty), 32'(1));
      pin = 1'b0;
      repeat (8) tick();
      clear_fifo();

      // T2: noise canceller rejects a 3-cycle glitch, passes a 6-cycle pulse
      cap.i_cap_nc_en = 1'b1;
      repeat (8) tick();
      cap.i_cap_edge = 2'b10;
      tick();
      pin = 1'b1;
      repeat (3) tick();
      pin = 1'b0;
      nflg = 0;
      repeat (12) begin
         tick();
         nflg += int'(cap.o_cap_ic_flg);
      end
      chk("t2_glitch", 32'(nflg), 32'(0));
      cap.i_cnt_data = 16'h00C0;
      pin = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk("t2_flg", 32'(cap.o_cap_ic_flg), 32'((i == 7) || (i == 13)));
         if (i == 6) pin = 1'b0;
      end
      chk("t2_head", 32'(cap.o_cap_cnt_data), 32'h00C0);
      clear_fifo();
      cap.i_cap_nc_en = 1'b0;
      cap.i_cap_edge  = 2'b00;
      repeat (6) tick();

      // T3: fill, overrun, then drain
      for (int k = 1; k <= 5; k++) pulse(DW'(16'h10 * k), 2, 4);
      chk("t3_ovr",  32'(cap.o_cap_ovr),      32'(1));
      chk("t3_head", 32'(cap.o_cap_cnt_data), 32'h0010);
      for (int k = 2; k <= 5; k++) begin
         cap.i_cap_rd = 1'b1;
         tick();
         cap.i_cap_rd = 1'b0;
         chk("t3_pop", 32'(cap.o_cap_cnt_data), (k <= 4) ? 32'(16'h10 * k) : 32'(0));
      end
      chk("t3_empty", 32'(cap.o_cap_not_empty), 32'(0));
      clear_fifo();
      chk("t3_ovr_clr", 32'(cap.o_cap_ovr), 32'(0));

      // T4: push and pop together while full, then clear against a push
      for (int k = 1; k <= 4; k++) pulse(DW'(16'hA0 + k), 2, 4);
      cap.i_cnt_data = 16'hA5;
      pin = 1'b1;
      repeat (3) tick();
      cap.i_cap_rd = 1'b1;
      tick();
      cap.i_cap_rd = 1'b0;
      chk("t4_ovr",  32'(cap.o_cap_ovr),      32'(0));
      chk("t4_head", 32'(cap.o_cap_cnt_data), 32'h00A2);
      pin = 1'b0;
      repeat (4) tick();
      repeat (3) begin
         cap.i_cap_rd = 1'b1;
         tick();
      end
      cap.i_cap_rd = 1'b0;
      chk("t4_tail", 32'(cap.o_cap_cnt_data), 32'h00A5);
      cap.i_cnt_data = 16'hA6;
      pin = 1'b1;
      repeat (3) tick();
      cap.i_cap_clr = 1'b1;
      tick();
      cap.i_cap_clr = 1'b0;
      chk("t4_clr_ne",  32'(cap.o_cap_not_empty), 32'(0));
      chk("t4_clr_ovr", 32'(cap.o_cap_ovr),       32'(0));

      // T5: pin high across reset release, then an edge while disabled
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      nflg = 0;
      repeat (10) begin
         tick();
         nflg += int'(cap.o_cap_ic_flg);
      end
      chk("t5_rel", 32'(nflg), 32'(0));
      pin = 1'b0;
      repeat (6) tick();
      cap.i_cap_en = 1'b0;
      pin = 1'b1;
      repeat (6) tick();
      cap.i_cap_en = 1'b1;
      repeat (6) tick();
      chk("t5_dis", 32'(cap.o_cap_not_empty), 32'(0));
      pin = 1'b0;
      repeat (4) tick();

      // T6: asynchronous reset with entries held, then a normal capture
      pulse(16'hB1, 2, 4);
      pulse(16'hB2, 2, 4);
      chk("t6_pre", 32'(cap.o_cap_not_empty), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_ne",   32'(cap.o_cap_not_empty), 32'(0));
      chk("t6_head", 32'(cap.o_cap_cnt_data),  32'(0));
      chk("t6_ovr",  32'(cap.o_cap_ovr),       32'(0));
      chk("t6_flg",  32'(cap.o_cap_ic_flg),    32'(0));
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      cap.i_cnt_data = 16'hC3;
      pin = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t6_flg_edge", 32'(cap.o_cap_ic_flg), 32'(i == 4));
      end
      chk("t6_cap", 32'(cap.o_cap_cnt_data), 32'h00C3);
      pin = 1'b0;
      repeat (4) tick();

      // Randomized traffic in bypass, then with the noise canceller
      rand_phase(1'b0, 300);
      rand_phase(1'b1, 300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
